tag_gen: RTL and testbench



---
 rtl/tag_pkg.sv | 18 +
 rtl/tag_gen.sv | 35 +++
 tb/tb_tag_gen.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tag_pkg.sv
// Shared constants and the keyed byte-fold function for the tag generator.
// Benches and other blocks use tag_fold as the canonical definition of a tag.
package tag_pkg;

  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;
  localparam logic [TAG_W-1:0] TAG_KEY = 8'hD6;

  function automatic logic [TAG_W-1:0] tag_fold(input logic [DATA_W-1:0] data);
    logic [TAG_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < DATA_W / TAG_W; i++) begin
      acc = acc ^ data[i*TAG_W +: TAG_W];
    end
    return acc ^ TAG_KEY;
  endfunction

endpackage

// File: rtl/tag_gen.sv
// Per-word tag source: XOR-folds the bytes of each data word, applies a key,
// and registers the result so the tag trails its data by one clock.
module tag_gen #(
  parameter int                    DATA_W  = tag_pkg::DATA_W,
  parameter int                    TAG_W   = tag_pkg::TAG_W,
  parameter logic [TAG_W-1:0]      TAG_KEY = tag_pkg::TAG_KEY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag
);

  logic [TAG_W-1:0] tag_d;
  logic [TAG_W-1:0] tag_q;

  // No carries between lanes, so X on any data bit propagates straight to the tag.
  always_comb begin
    tag_d = TAG_KEY;
    for (int i = 0; i < DATA_W / TAG_W; i++) begin
      tag_d = tag_d ^ data[i*TAG_W +: TAG_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag = tag_q;

endmodule

// File: tb/tb_tag_gen.sv
// Directed and randomized bench for tag_gen with an independent byte-fold model.
module tb_tag_gen;

  logic        clk;
  logic        reset;
  logic [31:0] data;
  logic [7:0]  tag;

  int errors = 0;
  int checks = 0;

  tag_gen dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .tag   (tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: XOR of the four byte values, then the key, via plain arithmetic.
  function automatic logic [7:0] ref_tag(input logic [31:0] d);
    int acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc = acc ^ int'((d >> (8 * k)) & 32'hFF);
    end
    acc = acc ^ 'hD6;
    return acc[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] dir_data [4] = '{32'h00000000, 32'hFFFFFFFF, 32'h000000FF, 32'hDEADBEEF};
  logic [7:0]  dir_tag  [4] = '{8'hD6, 8'hD6, 8'h29, 8'hF4};
  logic [31:0] b2b_data [3] = '{32'h12345678, 32'hDEADBEEF, 32'h00000000};
  logic [7:0]  b2b_tag  [3] = '{8'hDE, 8'hF4, 8'hD6};

  initial begin
    reset = 1'b0;
    data  = 32'h12345678;

    // Asynchronous reset assertion away from any clock edge.
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", tag, 8'h00);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check("reset_hold", tag, 8'h00);
    end

    // Release reset mid-cycle; first edge loads the tag of present data.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_release_no_edge", tag, 8'h00);
    edge_sample();
    check("nominal_12345678", tag, 8'hDE);
    @(negedge clk);
    check("nominal_hold", tag, 8'hDE);

    for (int i = 0; i < 4; i++) begin
      data = dir_data[i];
      edge_sample();
      check($sformatf("directed_%08h", dir_data[i]), tag, dir_tag[i]);
      check($sformatf("directed_model_%08h", dir_data[i]), tag, ref_tag(dir_data[i]));
    end

    // Back-to-back words: each tag appears one edge after its data.
    data = b2b_data[0];
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("b2b_%0d", i), tag, b2b_tag[i]);
      if (i < 2) data = b2b_data[i + 1];
    end

    // Tag must also update on an edge where data is unchanged (still holds value).
    edge_sample();
    check("unchanged_data", tag, 8'hD6);

    // Mid-stream reset pulse between edges.
    data = 32'hA5C3_0F11;
    edge_sample();
    check("pre_pulse", tag, ref_tag(32'hA5C3_0F11));
    data = 32'h0BAD_F00D;
    #1;
    reset = 1'b1;
    #1;
    check("midstream_async_clear", tag, 8'h00);
    #1;
    reset = 1'b0;
    #1;
    check("midstream_no_edge", tag, 8'h00);
    edge_sample();
    check("midstream_resume", tag, ref_tag(32'h0BAD_F00D));

    // Randomized stream against the model.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] d;
      d = $urandom;
      data = d;
      edge_sample();
      check("random", tag, ref_tag(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
